// File: rtl/alu_pkg.sv
// Shared ALU definitions: bus widths, opcode map, flag-bit positions.
package alu_pkg;

  localparam int unsigned BUS = 8;
  localparam int unsigned OP  = 6;

  localparam logic [OP-1:0] OP_ADD = 6'b100000;
  localparam logic [OP-1:0] OP_SUB = 6'b100010;
  localparam logic [OP-1:0] OP_AND = 6'b100100;
  localparam logic [OP-1:0] OP_OR  = 6'b100101;
  localparam logic [OP-1:0] OP_XOR = 6'b100110;
  localparam logic [OP-1:0] OP_SRA = 6'b000011;
  localparam logic [OP-1:0] OP_SRL = 6'b000010;
  localparam logic [OP-1:0] OP_NOR = 6'b100111;

  localparam int unsigned FLAG_ILLEGAL = 7;
  localparam int unsigned FLAG_ZERO    = 1;
  localparam int unsigned FLAG_CARRY   = 0;

  // Operands and opcode presented to the ALU as one unit
  typedef struct packed {
    logic [BUS-1:0] a;
    logic [BUS-1:0] b;
    logic [OP-1:0]  op;
  } alu_frame_t;

  // Full opcode byte is legal only with zero upper bits and a known low code
  function automatic logic is_legal_op(input logic [BUS-1:0] op_byte);
    logic legal;
    legal = 1'b0;
    if (op_byte[BUS-1:OP] == '0) begin
      case (op_byte[OP-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SRA, OP_SRL, OP_NOR: legal = 1'b1;
        default:                        legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Inter-byte idle counter: saturates at TIMEOUT_CYCLES and flags expiry.
module alu_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic          expired_q, expired_d;

  // Next count: clear wins, otherwise count up to the limit and hold there
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
    expired_d = (count_d == LIMIT);
  end

  // Counter and registered expiry flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/alu_rx_sequencer.sv
// Collects A/B/OP byte frames for the ALU and returns result and flags bytes.
module alu_rx_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [BUS-1:0] rx_data_i,
  input  logic           rx_valid_i,
  output logic [BUS-1:0] alu_a_o,
  output logic [BUS-1:0] alu_b_o,
  output logic [OP-1:0]  alu_op_o,
  input  logic [BUS-1:0] alu_rdo_i,
  input  logic           alu_carry_i,
  input  logic           alu_zero_i,
  output logic [BUS-1:0] tx_data_o,
  output logic           tx_start_o,
  input  logic           tx_done_i,
  output logic           illegal_op_o,
  output logic           rx_overrun_o
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND_RES,
    S_WAIT_RES,
    S_SEND_FLG,
    S_WAIT_FLG
  } seq_state_e;

  localparam alu_frame_t FRAME_RST = '{a: '0, b: '0, op: OP_ADD};

  seq_state_e     state_q, state_d;
  alu_frame_t     frame_q, frame_d;
  logic [BUS-1:0] a_hold_q, a_hold_d;
  logic [BUS-1:0] b_hold_q, b_hold_d;
  logic [BUS-1:0] result_q, result_d;
  logic [BUS-1:0] flags_q, flags_d;
  logic [BUS-1:0] tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           illegal_q, illegal_d;
  logic           overrun_q, overrun_d;

  logic           tmo_clr_c;
  logic           tmo_en_c;
  logic           tmo_exp;

  alu_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (tmo_clr_c),
    .enable_i (tmo_en_c),
    .expired_o(tmo_exp)
  );

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    result_d   = result_q;
    flags_d    = flags_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    illegal_d  = 1'b0;
    overrun_d  = overrun_q;
    tmo_clr_c  = 1'b0;
    tmo_en_c   = 1'b0;

    // Bytes arriving while the response is in flight are dropped
    if (rx_valid_i && (state_q != S_WAIT_A) && (state_q != S_WAIT_B) &&
        (state_q != S_WAIT_OP)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_WAIT_A: begin
        tmo_clr_c = 1'b1;
        if (rx_valid_i) begin
          a_hold_d = rx_data_i;
          state_d  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (rx_valid_i) begin
          tmo_clr_c = 1'b1;
          b_hold_d  = rx_data_i;
          state_d   = S_WAIT_OP;
        end else if (tmo_exp) begin
          state_d = S_WAIT_A;
        end else begin
          tmo_en_c = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (rx_valid_i) begin
          tmo_clr_c = 1'b1;
          if (is_legal_op(rx_data_i)) begin
            frame_d = '{a: a_hold_q, b: b_hold_q, op: rx_data_i[OP-1:0]};
            state_d = S_EXEC;
          end else begin
            // Illegal opcode: skip the ALU and answer with a canned response
            illegal_d              = 1'b1;
            result_d               = '0;
            flags_d                = '0;
            flags_d[FLAG_ILLEGAL]  = 1'b1;
            tx_data_d              = '0;
            tx_start_d             = 1'b1;
            state_d                = S_SEND_RES;
          end
        end else if (tmo_exp) begin
          state_d = S_WAIT_A;
        end else begin
          tmo_en_c = 1'b1;
        end
      end
      S_EXEC: begin
        result_d            = alu_rdo_i;
        flags_d             = '0;
        flags_d[FLAG_ZERO]  = alu_zero_i;
        flags_d[FLAG_CARRY] = alu_carry_i;
        tx_data_d           = alu_rdo_i;
        tx_start_d          = 1'b1;
        state_d             = S_SEND_RES;
      end
      S_SEND_RES: begin
        state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (tx_done_i) begin
          tx_data_d  = flags_q;
          tx_start_d = 1'b1;
          state_d    = S_SEND_FLG;
        end
      end
      S_SEND_FLG: begin
        state_d = S_WAIT_FLG;
      end
      S_WAIT_FLG: begin
        if (tx_done_i) begin
          state_d = S_WAIT_A;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_WAIT_A;
      frame_q    <= FRAME_RST;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      illegal_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      illegal_q  <= illegal_d;
      overrun_q  <= overrun_d;
    end
  end

  assign alu_a_o      = frame_q.a;
  assign alu_b_o      = frame_q.b;
  assign alu_op_o     = frame_q.op;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign illegal_op_o = illegal_q;
  assign rx_overrun_o = overrun_q;

endmodule

// File: doc/alu_rx_sequencer.md
Name: alu_rx_sequencer

Overview:
- Front-end stage that feeds the 8-bit ALU from a serial byte stream and returns its result.
- Collects a three-byte frame (A, B, OP) from an upstream byte receiver and drives registered operands into the ALU.
- Captures the ALU's rdo/carry/zero and hands two response bytes, result then flags, to a downstream byte transmitter.
- Also rejects illegal opcodes and abandons stalled frames.

Parameters:
- BUS, 8, data width; must match the ALU bus.
- OP, 6, opcode width; the low OP bits of the third byte.
- TIMEOUT_CYCLES, 50000000, idle cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  single system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  BUS  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- alu_a  out  BUS  registered ALU operand A.
- alu_b  out  BUS  registered ALU operand B.
- alu_op  out  OP  registered ALU opcode.
- alu_rdo  in  BUS  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_carry  in  1  ALU carry/borrow bit.
- alu_zero  in  1  ALU zero flag.
- tx_data  out  BUS  byte to transmit.
- tx_start  out  1  one-cycle request to send tx_data.
- tx_done  in  1  one-cycle strobe: transmitter finished the current byte.
- illegal_op  out  1  one-cycle pulse when a frame carries an illegal opcode.
- rx_overrun  out  1  sticky: a byte arrived while not accepting; cleared only by reset.

Behaviour:
- Reset values:
  - alu_a=0, alu_b=0, alu_op=6'b100000 (ADD, never an illegal code).
  - tx_data=0, tx_start=0, illegal_op=0, rx_overrun=0.
  - State is WAIT_A; timeout counter is 0.
- WAIT_A: on rx_valid, latch rx_data into the A holding register and go to WAIT_B.
- WAIT_B: on rx_valid, latch rx_data into the B holding register and go to WAIT_OP.
- WAIT_OP: on rx_valid, decode rx_data.
  - Legal means the upper BUS-OP bits are 0 and the low OP bits are one of ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Legal: load alu_a/alu_b/alu_op together from the holding registers and rx_data, then go to EXEC.
  - Illegal: alu_a/alu_b/alu_op keep their values; pulse illegal_op next cycle; force result=0x00 and flags=0x80; go to SEND_RES.
- Operand loading: alu_a/alu_b change only on a legal frame, all in the same edge, so the ALU never sees a mixed frame.
- EXEC: lasts exactly one cycle (ALU settles).
  - Capture result=alu_rdo and flags={1'b0,5'b0,alu_zero,alu_carry} at the end of the cycle.
  - Go to SEND_RES.
- SEND_RES: lasts one cycle, with tx_data=result and tx_start=1; go to WAIT_RES.
- WAIT_RES: tx_start=0, tx_data held; on tx_done go to SEND_FLG.
- SEND_FLG: lasts one cycle, with tx_data=flags and tx_start=1; go to WAIT_FLG.
- WAIT_FLG: tx_done returns to WAIT_A; tx_data holds its last value.
- Flags byte: bit7=illegal, bit1=zero, bit0=carry, all other bits 0.
- Latency: OP byte strobe at cycle T gives EXEC in cycle T+1 and tx_start (result byte) in cycle T+2.
- tx_done is sampled only in WAIT_RES/WAIT_FLG; a tx_done seen in any other state is ignored.
- An rx_valid outside WAIT_A/WAIT_B/WAIT_OP drops the byte and sets rx_overrun; the frame in flight is unaffected.
- Timeout counter:
  - Cleared on every accepted byte and in WAIT_A.
  - Counts in WAIT_B/WAIT_OP.
  - On reaching TIMEOUT_CYCLES, the partial frame is discarded and the state returns to WAIT_A; ALU outputs are unchanged.
  - rx_valid in the same cycle as expiry: the byte is accepted and the counter is cleared.
- Reset in any state, including mid-transmit, returns all outputs to their reset values on the next edge.
- Widths: alu_carry is bit 8 of the ALU's 9-bit result (borrow for SUB); no extension is performed here.

Decomposition:
- Shared package alu_pkg:
  - BUS/OP widths.
  - The eight opcode constants.
  - An is_legal_op function.
  - The flag-bit positions (ILLEGAL=7, ZERO=1, CARRY=0).
- ALU and sequencer both use alu_pkg.
- One sub-module, alu_seq_timeout: a counter with clear/enable/expired, parameterised by TIMEOUT_CYCLES.

Test Plan:
- A=0x05, B=0x03, OP=0x20 -> alu_op=100000; tx bytes 0x08 then 0x00; tx_start exactly 2 cycles after the OP strobe.
- A=0xFF, B=0x01, OP=0x20 -> tx 0x00 then 0x03 (carry=1, zero=1).
- After the previous frame, A=0x12, B=0x34, OP=0x3F -> illegal_op pulses once; alu_a/alu_b/alu_op stay 0xFF/0x01/100000; tx 0x00 then 0x80.
- A=0x10, B=0x20, then TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES=16 in bench) -> state WAIT_A; then A=0x00, B=0x01, OP=0x22 -> tx 0xFF then 0x01 (borrow).
- rx_valid with 0x55 during WAIT_RES; tx_done held off 10 cycles -> rx_overrun=1 and stays 1; response bytes unchanged; next frame starts clean.
- reset pulse during WAIT_FLG, then a late tx_done -> all outputs at reset values, no further tx_start; next frame A=0x0F, B=0xF0, OP=0x25 -> tx 0xFF then 0x00.
